clk_en_sched: RTL

CLK_EN_SCHED -- requirements
Module: clk_en_sched

---
 rtl/clk_en_sched.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: a fixed prescaler chain (1 MHz / 1 kHz / 100 Hz / 1 Hz strobes)
// plus a programmable-period strobe whose divisor is written through a valid/ready port.
module clk_en_sched #(
    parameter int PRE         = 100,
    parameter int D1K         = 1000,
    parameter int D100        = 10,
    parameter int D1          = 100,
    parameter int DIV_W       = 27,
    parameter int DIV_DEFAULT = 100000000
) (
    input  logic             fpga_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             tick_1mhz,
    output logic             tick_1khz,
    output logic             tick_100hz,
    output logic             tick_1hz,
    output logic             tick_prog,
    output logic             running
);

    localparam int PRE_W  = (PRE  > 1) ? $clog2(PRE)  : 1;
    localparam int D1K_W  = (D1K  > 1) ? $clog2(D1K)  : 1;
    localparam int D100_W = (D100 > 1) ? $clog2(D100) : 1;
    localparam int D1_W   = (D1   > 1) ? $clog2(D1)   : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, next_state;

    logic [PRE_W-1:0]  pre_cnt;
    logic [D1K_W-1:0]  k_cnt;
    logic [D100_W-1:0] h_cnt;
    logic [D1_W-1:0]   s_cnt;
    logic [DIV_W-1:0]  prog_cnt;
    logic [DIV_W-1:0]  div_reg;
    logic [DIV_W-1:0]  pend_div;
    logic              pending;

    logic              advance;
    logic              to_idle;
    logic              accept;
    logic              pre_wrap;
    logic              k_wrap;
    logic              h_wrap;
    logic              s_wrap;
    logic              prog_wrap;
    logic [DIV_W-1:0]  cfg_clamped;

    always_ff @(posedge fpga_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Simultaneous start and stop always resolves to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && !stop) next_state = RUN;
            RUN:     if (stop)           next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        advance     = (state == RUN) && (next_state == RUN);
        to_idle     = (state == RUN) && (next_state == IDLE);
        accept      = cfg_valid && cfg_ready;
        cfg_clamped = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
        pre_wrap    = (pre_cnt == PRE_W'(PRE - 1));
        k_wrap      = pre_wrap && (k_cnt == D1K_W'(D1K - 1));
        h_wrap      = k_wrap && (h_cnt == D100_W'(D100 - 1));
        s_wrap      = h_wrap && (s_cnt == D1_W'(D1 - 1));
        prog_wrap   = (prog_cnt == (div_reg - DIV_W'(1)));
    end

    // Counters and strobes only move while RUN persists across the edge; entering or
    // leaving RUN clears every phase so a restart is cycle-identical to the first run.
    always_ff @(posedge fpga_clk or negedge reset) begin
        if (!reset) begin
            pre_cnt    <= '0;
            k_cnt      <= '0;
            h_cnt      <= '0;
            s_cnt      <= '0;
            prog_cnt   <= '0;
            tick_1mhz  <= 1'b0;
            tick_1khz  <= 1'b0;
            tick_100hz <= 1'b0;
            tick_1hz   <= 1'b0;
            tick_prog  <= 1'b0;
        end else if (!advance) begin
            pre_cnt    <= '0;
            k_cnt      <= '0;
            h_cnt      <= '0;
            s_cnt      <= '0;
            prog_cnt   <= '0;
            tick_1mhz  <= 1'b0;
            tick_1khz  <= 1'b0;
            tick_100hz <= 1'b0;
            tick_1hz   <= 1'b0;
            tick_prog  <= 1'b0;
        end else begin
            tick_1mhz  <= pre_wrap;
            tick_1khz  <= k_wrap;
            tick_100hz <= h_wrap;
            tick_1hz   <= s_wrap;
            tick_prog  <= prog_wrap;
            pre_cnt    <= pre_wrap ? '0 : pre_cnt + PRE_W'(1);
            if (pre_wrap) begin
                k_cnt <= k_wrap ? '0 : k_cnt + D1K_W'(1);
            end
            if (k_wrap) begin
                h_cnt <= h_wrap ? '0 : h_cnt + D100_W'(1);
            end
            if (h_wrap) begin
                s_cnt <= s_wrap ? '0 : s_cnt + D1_W'(1);
            end
            prog_cnt <= prog_wrap ? '0 : prog_cnt + DIV_W'(1);
        end
    end

    // A write taken mid-run is parked until the current programmable period ends, or
    // until stop, so the running period never sees a divisor change.
    always_ff @(posedge fpga_clk or negedge reset) begin
        if (!reset) begin
            div_reg  <= DIV_W'(DIV_DEFAULT);
            pend_div <= '0;
            pending  <= 1'b0;
        end else if (state == IDLE) begin
            pending <= 1'b0;
            if (accept) begin
                div_reg <= cfg_clamped;
            end
        end else if (to_idle) begin
            pending <= 1'b0;
            if (pending) begin
                div_reg <= pend_div;
            end else if (accept) begin
                div_reg <= cfg_clamped;
            end
        end else begin
            if (pending && prog_wrap) begin
                div_reg <= pend_div;
                pending <= 1'b0;
            end else if (accept) begin
                pend_div <= cfg_clamped;
                pending  <= 1'b1;
            end
        end
    end

    assign cfg_ready = ~pending;
    assign running   = (state == RUN);

endmodule
